// File: rtl/morse_stream_encoder.sv
// Buffered International Morse keyer: symbols in over valid/ready, FIFO-queued,
// keyed onto a single registered output with a programmable dot length.
module morse_stream_encoder #(
    parameter int UNIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sym_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       flush_i,
    output logic       out_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [5:0] SYM_SPACE = 6'd36;

    typedef enum logic [2:0] {IDLE, LOAD, MARK, EGAP, CGAP, WSPACE} state_e;

    // {element count, pattern left-aligned so bit 4 is the first element; 1 = dash}
    function automatic logic [7:0] rom(input logic [5:0] s);
        logic [7:0] e;
        e = 8'h00;
        case (s)
            6'd0:  e = {3'd2, 5'b01000};
            6'd1:  e = {3'd4, 5'b10000};
            6'd2:  e = {3'd4, 5'b10100};
            6'd3:  e = {3'd3, 5'b10000};
            6'd4:  e = {3'd1, 5'b00000};
            6'd5:  e = {3'd4, 5'b00100};
            6'd6:  e = {3'd3, 5'b11000};
            6'd7:  e = {3'd4, 5'b00000};
            6'd8:  e = {3'd2, 5'b00000};
            6'd9:  e = {3'd4, 5'b01110};
            6'd10: e = {3'd3, 5'b10100};
            6'd11: e = {3'd4, 5'b01000};
            6'd12: e = {3'd2, 5'b11000};
            6'd13: e = {3'd2, 5'b10000};
            6'd14: e = {3'd3, 5'b11100};
            6'd15: e = {3'd4, 5'b01100};
            6'd16: e = {3'd4, 5'b11010};
            6'd17: e = {3'd3, 5'b01000};
            6'd18: e = {3'd3, 5'b00000};
            6'd19: e = {3'd1, 5'b10000};
            6'd20: e = {3'd3, 5'b00100};
            6'd21: e = {3'd4, 5'b00010};
            6'd22: e = {3'd3, 5'b01100};
            6'd23: e = {3'd4, 5'b10010};
            6'd24: e = {3'd4, 5'b10110};
            6'd25: e = {3'd4, 5'b11000};
            6'd26: e = {3'd5, 5'b11111};
            6'd27: e = {3'd5, 5'b01111};
            6'd28: e = {3'd5, 5'b00111};
            6'd29: e = {3'd5, 5'b00011};
            6'd30: e = {3'd5, 5'b00001};
            6'd31: e = {3'd5, 5'b00000};
            6'd32: e = {3'd5, 5'b10000};
            6'd33: e = {3'd5, 5'b11000};
            6'd34: e = {3'd5, 5'b11100};
            6'd35: e = {3'd5, 5'b11110};
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    logic [5:0]    mem_q [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, accept, sym_ok, push, pop;

    state_e        state_q, state_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [1:0]    mult_q, mult_d;
    logic [4:0]    shreg_q, shreg_d;
    logic [2:0]    elems_q, elems_d;
    logic          out_q, err_q;
    logic [5:0]    head;
    logic [7:0]    rom_e;
    logic          unit_last, phase_done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign in_ready_o = !fifo_full && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign sym_ok     = (sym_i <= SYM_SPACE);
    // Invalid codes complete the handshake but never occupy a FIFO slot.
    assign push       = accept && sym_ok;
    assign pop        = (state_q == LOAD) && !flush_i;

    // NOTE: storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= sym_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        head       = mem_q[rd_ptr_q[PW-1:0]];
        rom_e      = rom(head);
        unit_last  = (unit_q == UNIT_LAST);
        phase_done = unit_last && (mult_q == 2'd0);
        state_d    = state_q;
        unit_d     = unit_q;
        mult_d     = mult_q;
        shreg_d    = shreg_q;
        elems_d    = elems_q;

        if (state_q inside {MARK, EGAP, CGAP, WSPACE}) begin
            if (unit_last) begin
                unit_d = '0;
                mult_d = mult_q - 2'd1;
            end else begin
                unit_d = unit_q + UW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                unit_d = '0;
                if (head == SYM_SPACE) begin
                    state_d = WSPACE;
                    mult_d  = 2'd3;
                end else begin
                    state_d = MARK;
                    shreg_d = rom_e[4:0];
                    elems_d = rom_e[7:5] - 3'd1;
                    mult_d  = rom_e[4] ? 2'd2 : 2'd0;
                end
            end
            MARK: begin
                if (phase_done) begin
                    if (elems_q != 3'd0) begin
                        state_d = EGAP;
                        mult_d  = 2'd0;
                        shreg_d = {shreg_q[3:0], 1'b0};
                        elems_d = elems_q - 3'd1;
                    end else begin
                        state_d = CGAP;
                        mult_d  = 2'd2;
                    end
                end
            end
            EGAP: begin
                if (phase_done) begin
                    state_d = MARK;
                    mult_d  = shreg_q[4] ? 2'd2 : 2'd0;
                end
            end
            CGAP, WSPACE: begin
                if (phase_done) state_d = fifo_empty ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            unit_q  <= '0;
            mult_q  <= '0;
            shreg_q <= '0;
            elems_q <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            mult_q  <= mult_d;
            shreg_q <= shreg_d;
            elems_q <= elems_d;
            out_q   <= (state_d == MARK);
            err_q   <= accept && !sym_ok;
        end
    end

    assign out_o  = out_q;
    assign err_o  = err_q;
    assign busy_o = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_morse_stream_encoder.sv
// Bench for morse_stream_encoder: a timeline model built from dot/dash strings
// checks every cycle, plus literal run-length pins for each scenario.
module tb_morse_stream_encoder;
    localparam int U     = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] sym_i = '0;
    logic       in_valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       in_ready_o, out_o, busy_o, err_o;

    logic [5:0] sym1 = '0;
    logic       v1 = 1'b0;
    logic       flush1 = 1'b0;
    logic       ready1, out1, busy1, err1;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    bit out_log[$];
    bit err_log[$];

    morse_stream_encoder #(.UNIT_CYCLES(U), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sym_i(sym_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .out_o(out_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    morse_stream_encoder #(.UNIT_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .sym_i(sym1), .in_valid_i(v1),
        .in_ready_o(ready1), .flush_i(flush1), .out_o(out1),
        .busy_o(busy1), .err_o(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // ---------------- model ----------------
    string mtab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

    bit exp_q[$];
    int pend[$];
    bit m_out = 0, m_busy = 0, m_err = 0, m_act = 0, m_acc = 0;
    int m_load = 0;

    function automatic bit model_ready();
        return !flush_i && ((pend.size() + m_load) < DEPTH);
    endfunction

    // One LOAD cycle, then the character's marks/gaps, ending with its 3-unit gap.
    task automatic expand(input int s);
        string code;
        byte   ch;
        exp_q.push_back(1'b0);
        if (s == 36) begin
            repeat (4 * U) exp_q.push_back(1'b0);
        end else begin
            code = mtab[s];
            for (int i = 0; i < code.len(); i++) begin
                ch = code[i];
                repeat (((ch == "-") ? 3 : 1) * U) exp_q.push_back(1'b1);
                repeat (((i == code.len() - 1) ? 3 : 1) * U) exp_q.push_back(1'b0);
            end
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            exp_q.delete();
            pend.delete();
            m_out = 0; m_busy = 0; m_err = 0; m_load = 0;
        end else begin
            m_acc = in_valid_i && model_ready();
            m_act = 0; m_load = 0; m_out = 0; m_err = 0;
            if (flush_i) begin
                exp_q.delete();
                pend.delete();
            end else begin
                if (exp_q.size() == 0 && pend.size() != 0) begin
                    expand(pend.pop_front());
                    m_load = 1;
                end
                if (exp_q.size() != 0) begin
                    m_out = exp_q.pop_front();
                    m_act = 1;
                end
                m_err = m_acc && (sym_i > 6'd36);
                if (m_acc && sym_i <= 6'd36) pend.push_back(int'(sym_i));
            end
            m_busy = m_act || (pend.size() != 0);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        out_log.push_back(out_o);
        err_log.push_back(err_o);
        ncyc++;
        check("out", out_o, m_out);
        check("busy", busy_o, m_busy);
        check("err", err_o, m_err);
        check("in_ready", in_ready_o, model_ready());
    end

    // ---------------- helpers ----------------
    task automatic send(input logic [5:0] s, output int t_acc);
        int   g;
        logic rdy;
        g = 0;
        rdy = 1'b0;
        sym_i = s;
        in_valid_i = 1'b1;
        while (!rdy && g < 200) begin
            @(negedge clk);
            rdy = in_ready_o;
            @(posedge clk);
            g++;
        end
        #1;
        in_valid_i = 1'b0;
        t_acc = ncyc;
        check("send_accepted", rdy, 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy_o && g < 3000);
        check("idle_reached", busy_o, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_high();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_o && g < 200);
        check("mark_seen", out_o, 1);
    endtask

    function automatic int find_high(input int from);
        for (int i = from; i < out_log.size(); i++) if (out_log[i]) return i;
        return -1;
    endfunction

    function automatic int run_len(input int from);
        int n;
        n = 0;
        if (from < 0 || from >= out_log.size()) return 0;
        while (from + n < out_log.size() && out_log[from + n] == out_log[from]) n++;
        return n;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, t2, f, p, errs;
        int ta[6];
        logic [12:0] r_out, r_busy;
        int r_a5 [13];
        logic [5:0] fill [6];

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out", out_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", in_ready_o, 1);

        // 'R' at one cycle per unit: .-. then 3 off, then idle
        r_out  = 13'b0010111010000;
        r_busy = 13'b1111111111110;
        check("r_ready", ready1, 1);
        sym1 = 6'd17;
        v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("r_out", out1, r_out[12 - i]);
            check("r_busy", busy1, r_busy[12 - i]);
            check("r_err", err1, 0);
        end
        @(posedge clk);
        #1;

        // 'A' then '5' back to back
        r_a5 = '{2, 2, 6, 7, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        send(6'd0, t);
        send(6'd31, t2);
        wait_idle();
        f = find_high(t);
        check("a5_first_high", f - t, 2);
        p = f;
        for (int i = 0; i < 13; i++) begin
            check("a5_run", run_len(p), r_a5[i]);
            p = p + r_a5[i];
        end

        // six pushes with valid held: five quickly, sixth after first character
        fill = '{6'd4, 6'd19, 6'd8, 6'd12, 6'd18, 6'd26};
        for (int i = 0; i < 6; i++) send(fill[i], ta[i]);
        check("fill_fast_five", ta[4] - ta[0], 4);
        check("fill_sixth", ta[5] - ta[0], 12);
        wait_idle();

        // E, word space, E
        send(6'd4, t);
        send(6'd36, t2);
        send(6'd4, t2);
        wait_idle();
        f = find_high(t);
        check("ese_mark1", run_len(f), 2);
        check("ese_gap", run_len(f + 2), 16);
        check("ese_mark2", run_len(f + 18), 2);

        // invalid symbol then 'T'
        send(6'd40, t);
        send(6'd19, t2);
        wait_idle();
        check("inv_err_pulse", err_log[t], 1);
        errs = 0;
        for (int i = t - 1; i < err_log.size(); i++) errs += int'(err_log[i]);
        check("inv_err_count", errs, 1);
        f = find_high(t2);
        check("t_first_high", f - t2, 2);
        check("t_mark_len", run_len(f), 6);

        // flush mid-dash with a concurrent valid
        send(6'd26, t);
        send(6'd14, t);
        send(6'd12, t);
        wait_high();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        sym_i = 6'd4;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_out", out_o, 0);
        check("flush_busy", busy_o, 0);
        repeat (6) @(negedge clk);
        check("flush_stays_idle", busy_o, 0);
        @(posedge clk);
        #1;

        // asynchronous reset mid-character
        send(6'd14, t);
        wait_high();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out", out_o, 0);
        check("arst_busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(6'd4, t);
        wait_idle();
        f = find_high(t);
        check("post_rst_first_high", f - t, 2);
        check("post_rst_mark_len", run_len(f), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
